spidergon_traffic_gen: RTL

Per-node traffic injector that builds wormhole packets (head/body/tail flits) and drives them into the local injection port of one Spidergon NoC node. There is one instance per node, in the NoC-level bench and in formal harnesses. It drives valid/ready handshakes, selects a virtual channel per packet, and chooses destinations as either fixed or LFSR-random. Destinations never equal its own node.

---
 rtl/spidergon_traffic_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spidergon_traffic_gen.sv
// Per-node wormhole packet injector for a Spidergon NoC node: builds head/body/tail flits,
// picks a fixed or LFSR-random destination (never its own node) and rotates the VC per packet.
module spidergon_traffic_gen #(
    parameter int unsigned  NUM_OF_NODES            = 8,
    parameter int unsigned  FLIT_DATA_WIDTH         = 16,
    parameter int unsigned  NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int unsigned  SRC_NODE                = 0,
    parameter int unsigned  PACKET_LEN              = 4,
    parameter logic [15:0]  LFSR_SEED               = 16'hACE1,
    localparam int unsigned NODE_ID_W               = $clog2(NUM_OF_NODES),
    localparam int unsigned SEQ_W                   = FLIT_DATA_WIDTH - 2 - 2 * NODE_ID_W,
    localparam int unsigned VC_W                    = (NUM_OF_VIRTUAL_CHANNELS > 1) ?
                                                      $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       cfg_random_dest,
    input  logic [NODE_ID_W-1:0]       cfg_fixed_dest,
    input  logic [7:0]                 cfg_inject_gap,
    output logic [FLIT_DATA_WIDTH-1:0] flit_out,
    output logic                       flit_valid,
    output logic [VC_W-1:0]            flit_vc,
    input  logic                       flit_ready,
    output logic                       busy,
    output logic [15:0]                pkt_count
);

    localparam int unsigned IDX_W = 2 * NODE_ID_W;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StHead = 3'd1;
    localparam logic [2:0] StBody = 3'd2;
    localparam logic [2:0] StTail = 3'd3;
    localparam logic [2:0] StGap  = 3'd4;

    localparam logic [NODE_ID_W-1:0] SrcId    = NODE_ID_W'(SRC_NODE);
    localparam logic [NODE_ID_W-1:0] AcrossId =
        NODE_ID_W'((SRC_NODE + NUM_OF_NODES / 2) % NUM_OF_NODES);
    localparam logic [IDX_W-1:0]     LastBodyIdx =
        IDX_W'((PACKET_LEN > 1) ? (PACKET_LEN - 2) : 0);
    localparam logic [VC_W-1:0]      LastVc   = VC_W'(NUM_OF_VIRTUAL_CHANNELS - 1);
    localparam logic [1:0]           HeadType = (PACKET_LEN == 1) ? 2'b11 : 2'b01;

    logic [2:0]           state_q, state_d;
    logic [SEQ_W-1:0]     seq_q;
    logic [NODE_ID_W-1:0] dest_q;
    logic [IDX_W-1:0]     idx_q;
    logic [VC_W-1:0]      vc_q;
    logic [15:0]          lfsr_q;
    logic [7:0]           gap_cnt_q;
    logic [15:0]          pkt_count_q;

    logic                 xfer;
    logic                 start_pkt;
    logic                 pkt_end;
    logic [NODE_ID_W-1:0] dest_cand;
    logic [NODE_ID_W-1:0] dest_next;

    assign busy       = (state_q == StHead) || (state_q == StBody) || (state_q == StTail);
    assign flit_valid = busy;
    assign flit_vc    = vc_q;
    assign pkt_count  = pkt_count_q;
    assign xfer       = flit_valid && flit_ready;

    // A random pick that lands on this node is redirected across the ring.
    assign dest_cand = cfg_random_dest ? lfsr_q[NODE_ID_W-1:0] : cfg_fixed_dest;
    assign dest_next = (dest_cand == SrcId) ? AcrossId : dest_cand;

    always_comb begin
        state_d   = state_q;
        start_pkt = 1'b0;
        pkt_end   = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d   = StHead;
                    start_pkt = 1'b1;
                end
            end
            StHead: begin
                if (xfer) begin
                    if (PACKET_LEN == 1)      pkt_end = 1'b1;
                    else if (PACKET_LEN == 2) state_d = StTail;
                    else                      state_d = StBody;
                end
            end
            StBody: begin
                if (xfer && (idx_q == LastBodyIdx)) state_d = StTail;
            end
            StTail: begin
                if (xfer) pkt_end = 1'b1;
            end
            StGap: begin
                if (gap_cnt_q <= 8'd1) begin
                    if (enable) begin
                        state_d   = StHead;
                        start_pkt = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pkt_end) begin
            if (cfg_inject_gap != 8'd0) begin
                state_d = StGap;
            end else if (enable) begin
                state_d   = StHead;
                start_pkt = 1'b1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        flit_out = '0;
        case (state_q)
            StHead:  flit_out = {HeadType, seq_q, SrcId, dest_q};
            StBody:  flit_out = {2'b00, seq_q, idx_q};
            StTail:  flit_out = {2'b10, seq_q, idx_q};
            default: flit_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            seq_q       <= '0;
            dest_q      <= '0;
            idx_q       <= '0;
            vc_q        <= '0;
            lfsr_q      <= LFSR_SEED;
            gap_cnt_q   <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_pkt) dest_q <= dest_next;
            if (xfer && (state_q == StHead)) begin
                idx_q  <= IDX_W'(1);
                lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            end else if (xfer && (state_q == StBody)) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == StGap) gap_cnt_q <= gap_cnt_q - 8'd1;
            if (pkt_end) begin
                gap_cnt_q   <= cfg_inject_gap;
                seq_q       <= seq_q + 1'b1;
                pkt_count_q <= pkt_count_q + 16'd1;
                vc_q        <= (vc_q == LastVc) ? '0 : vc_q + 1'b1;
            end
        end
    end

endmodule
